coax_rx_frame_ctrl: RTL and testbench

//  Frame-level controller sequencing coax_rx_bit_timer. Consumes the timer's sample/synchronized

---
 rtl/coax_rx_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_coax_rx_frame_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/coax_rx_frame_ctrl.sv
// Frame-level receive controller: preamble/delimiter detection, 10-bit word assembly with
// even parity, end-of-frame and error reporting, and re-arming of the coax bit timer.
module coax_rx_frame_ctrl #(
    parameter int unsigned PREAMBLE_BITS  = 5,
    parameter int unsigned SAMPLE_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       sample,
    input  logic       synchronized,
    output logic       bit_timer_reset,
    output logic       active,
    output logic [9:0] data,
    output logic       data_strobe,
    output logic       frame_done,
    output logic [1:0] error,
    output logic       error_strobe
);

    localparam int unsigned OW = $clog2(PREAMBLE_BITS + 1);
    localparam int unsigned TW = $clog2(SAMPLE_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StPreamble, StSync, StData, StParity} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] ones_count_q, ones_count_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [3:0]    bit_count_q, bit_count_d;
    logic [7:0]    word_count_q, word_count_d;
    logic [9:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [9:0]    data_q, data_d;
    logic [1:0]    error_q, error_d;
    logic          active_q, active_d;
    logic          data_strobe_q, data_strobe_d;
    logic          frame_done_q, frame_done_d;
    logic          error_strobe_q, error_strobe_d;
    logic          btr_q, btr_d;

    logic in_frame;
    logic timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ones_count_q   <= '0;
            timeout_q      <= '0;
            bit_count_q    <= '0;
            word_count_q   <= '0;
            shift_q        <= '0;
            parity_q       <= 1'b0;
            data_q         <= '0;
            error_q        <= '0;
            active_q       <= 1'b0;
            data_strobe_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            error_strobe_q <= 1'b0;
            btr_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ones_count_q   <= ones_count_d;
            timeout_q      <= timeout_d;
            bit_count_q    <= bit_count_d;
            word_count_q   <= word_count_d;
            shift_q        <= shift_d;
            parity_q       <= parity_d;
            data_q         <= data_d;
            error_q        <= error_d;
            active_q       <= active_d;
            data_strobe_q  <= data_strobe_d;
            frame_done_q   <= frame_done_d;
            error_strobe_q <= error_strobe_d;
            btr_q          <= btr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ones_count_d   = ones_count_q;
        bit_count_d    = bit_count_q;
        word_count_d   = word_count_q;
        shift_d        = shift_q;
        parity_d       = parity_q;
        data_d         = data_q;
        error_d        = error_q;
        active_d       = active_q;
        data_strobe_d  = 1'b0;
        frame_done_d   = 1'b0;
        error_strobe_d = 1'b0;
        btr_d          = 1'b0;

        in_frame  = (state_q == StSync) || (state_q == StData) || (state_q == StParity);
        timeout_d = '0;
        if (in_frame && !sample) begin
            timeout_d = timeout_q + 1'b1;
        end
        timed_out = in_frame && !sample && (timeout_q == TW'(SAMPLE_TIMEOUT - 1));

        unique case (state_q)
            StIdle: begin
                if (sample && synchronized && rx) begin
                    state_d      = StPreamble;
                    ones_count_d = OW'(1);
                end
            end
            StPreamble: begin
                if (!synchronized) begin
                    state_d      = StIdle;
                    ones_count_d = '0;
                end else if (sample) begin
                    if (rx) begin
                        if (ones_count_q < OW'(PREAMBLE_BITS)) begin
                            ones_count_d = ones_count_q + 1'b1;
                        end
                    end else if (ones_count_q >= OW'(PREAMBLE_BITS)) begin
                        state_d      = StSync;
                        active_d     = 1'b1;
                        error_d      = 2'd0;
                        word_count_d = '0;
                        ones_count_d = '0;
                    end else begin
                        ones_count_d = '0;
                    end
                end
            end
            StSync, StData, StParity: begin
                // Loss of sync beats both a same-cycle sample and a timeout.
                if (!synchronized || timed_out) begin
                    state_d        = StIdle;
                    error_d        = !synchronized ? 2'd2 : 2'd3;
                    error_strobe_d = 1'b1;
                    btr_d          = 1'b1;
                    active_d       = 1'b0;
                end else if (sample) begin
                    if (state_q == StSync) begin
                        if (rx) begin
                            state_d     = StData;
                            bit_count_d = '0;
                            parity_d    = 1'b0;
                        end else begin
                            state_d      = StIdle;
                            frame_done_d = 1'b1;
                            btr_d        = 1'b1;
                            active_d     = 1'b0;
                        end
                    end else if (state_q == StData) begin
                        shift_d     = {shift_q[8:0], rx};
                        parity_d    = parity_q ^ rx;
                        bit_count_d = bit_count_q + 1'b1;
                        if (bit_count_q == 4'd9) begin
                            state_d = StParity;
                        end
                    end else if ((parity_q ^ rx) == 1'b0) begin
                        state_d       = StSync;
                        data_d        = shift_q;
                        data_strobe_d = 1'b1;
                        word_count_d  = word_count_q + 1'b1;
                    end else begin
                        state_d        = StIdle;
                        error_d        = 2'd1;
                        error_strobe_d = 1'b1;
                        btr_d          = 1'b1;
                        active_d       = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bit_timer_reset = btr_q;
        active          = active_q;
        data            = data_q;
        data_strobe     = data_strobe_q;
        frame_done      = frame_done_q;
        error           = error_q;
        error_strobe    = error_strobe_q;
    end

endmodule

// File: tb/tb_coax_rx_frame_ctrl.sv
// Directed bench for coax_rx_frame_ctrl: table of whole frames plus hand sequences for
// loss of sync, timeout and mid-frame reset.
module tb_coax_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset, rx, sample, synchronized;
    logic       bit_timer_reset, active, data_strobe, frame_done, error_strobe;
    logic [9:0] data;
    logic [1:0] error;

    int errors = 0;
    int checks = 0;
    int n_ds, n_fd, n_es, n_btr;
    logic [9:0] words[$];

    coax_rx_frame_ctrl #(.PREAMBLE_BITS(5), .SAMPLE_TIMEOUT(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .sample          (sample),
        .synchronized    (synchronized),
        .bit_timer_reset (bit_timer_reset),
        .active          (active),
        .data            (data),
        .data_strobe     (data_strobe),
        .frame_done      (frame_done),
        .error           (error),
        .error_strobe    (error_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        int          len;
        int          n_ds;
        logic [9:0]  w0;
        logic [9:0]  w1;
        int          n_fd;
        int          n_es;
        int          n_btr;
        logic [1:0]  err;
        logic [9:0]  data;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_tally();
        n_ds = 0; n_fd = 0; n_es = 0; n_btr = 0;
        words.delete();
    endtask

    task automatic step(input logic r, input logic s, input logic sy, input logic rst);
        int npulse;
        rx = r; sample = s; synchronized = sy; reset = rst;
        @(posedge clk);
        #1;
        if (data_strobe) begin
            n_ds++;
            words.push_back(data);
        end
        if (frame_done) n_fd++;
        if (error_strobe) n_es++;
        if (bit_timer_reset) n_btr++;
        npulse = int'(data_strobe) + int'(frame_done) + int'(error_strobe);
        if (npulse > 1) chk("pulse_exclusive", npulse, 1);
    endtask

    task automatic feed(input logic [63:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        int n;
        bit found;

        vecs[0] = '{64'b11111_0_1_1010100101_1_0, 19, 1, 10'h2A5, 10'h000, 1, 0, 1, 2'd0, 10'h2A5};
        vecs[1] = '{64'b11111_0_1_1111111111_0_1_0000000001_1_0, 31, 2, 10'h3FF, 10'h001,
                    1, 0, 1, 2'd0, 10'h001};
        vecs[2] = '{64'b111_0_11111_0_1_1010100101_1_0, 23, 1, 10'h2A5, 10'h000,
                    1, 0, 1, 2'd0, 10'h2A5};
        vecs[3] = '{64'b11111_0_1_0101010101_0, 18, 0, 10'h000, 10'h000, 0, 1, 1, 2'd1, 10'h2A5};
        vecs[4] = '{64'b00_11111_0_0, 9, 0, 10'h000, 10'h000, 1, 0, 1, 2'd0, 10'h2A5};

        clear_tally();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_active", active, 0);
        chk("reset_data", data, 0);
        chk("reset_error", error, 0);
        chk("reset_pulses", {bit_timer_reset, data_strobe, frame_done, error_strobe}, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        for (int v = 0; v < 5; v++) begin
            clear_tally();
            feed(vecs[v].bits, vecs[v].len);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("v%0d_n_strobe", v), n_ds, vecs[v].n_ds);
            if (words.size() > 0) chk($sformatf("v%0d_word0", v), words[0], vecs[v].w0);
            if (words.size() > 1) chk($sformatf("v%0d_word1", v), words[1], vecs[v].w1);
            chk($sformatf("v%0d_frame_done", v), n_fd, vecs[v].n_fd);
            chk($sformatf("v%0d_error_strobe", v), n_es, vecs[v].n_es);
            chk($sformatf("v%0d_timer_reset", v), n_btr, vecs[v].n_btr);
            chk($sformatf("v%0d_error", v), error, vecs[v].err);
            chk($sformatf("v%0d_data", v), data, vecs[v].data);
            chk($sformatf("v%0d_active", v), active, 0);
        end

        // Preamble drop is silent: delimiter after resync must not be accepted.
        clear_tally();
        feed(64'b11111, 5);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed(64'b0, 1);
        chk("pre_drop_active", active, 0);
        chk("pre_drop_timer_reset", n_btr, 0);
        chk("pre_drop_error_strobe", n_es, 0);

        // Loss of sync mid-DATA, without and with a same-cycle sample.
        for (int k = 0; k < 2; k++) begin
            clear_tally();
            feed(64'b11111_0_1_101, 10);
            chk($sformatf("los%0d_active_mid", k), active, 1);
            step(1'b1, k[0], 1'b0, 1'b0);
            chk($sformatf("los%0d_error_strobe", k), error_strobe, 1);
            chk($sformatf("los%0d_error", k), error, 2'd2);
            chk($sformatf("los%0d_active", k), active, 0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("los%0d_timer_reset", k), n_btr, 1);
            chk($sformatf("los%0d_strobes", k), n_ds + n_fd, 0);
        end

        // Timeout in SYNC: error after exactly 32 sample-free clocks.
        clear_tally();
        feed(64'b11111, 5);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
            if (error_strobe) found = 1;
        end
        chk("timeout_seen", found, 1);
        chk("timeout_clocks", n, 32);
        chk("timeout_error", error, 2'd3);
        chk("timeout_active", active, 0);
        chk("timeout_timer_reset", n_btr, 1);

        // Reset mid-DATA: outputs return to reset values, no pulses.
        clear_tally();
        feed(64'b11111_0_1_1111, 11);
        chk("rst_active_mid", active, 1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_active", active, 0);
        chk("rst_data", data, 0);
        chk("rst_error", error, 0);
        chk("rst_pulses", {bit_timer_reset, data_strobe, frame_done, error_strobe}, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_no_strobes", n_ds + n_fd + n_es + n_btr, 0);

        // Recovery after reset.
        clear_tally();
        feed(vecs[0].bits, vecs[0].len);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("recover_data", data, 10'h2A5);
        chk("recover_frame_done", n_fd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
